// File: rtl/seq_feed_buffer.sv
// rtl/seq_feed_buffer.sv - sequence store and diagonal feeder for a PU array
//
// Purpose:
//   Loads a packed letter sequence over a valid/ready word stream. It stores
//   the sequence as SEQ_LENGTH letters, optionally in reversed order. It then
//   streams the sequence to NUM_PU processing units one diagonal at a time.
//   On diagonal d, PU k receives letter group (d - k), each group being NLC
//   letters. When that group does not exist, PU k receives zeros and its mask
//   bit is low.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a new load (restarts from any state, clears storage)
//   in_valid    - input word valid
//   in_data     - packed letters, letter j at [LETTER_WIDTH*j +: LETTER_WIDTH]
//   in_ready    - buffer accepts a word (LOAD state)
//   load_done   - full sequence stored, waiting for the first feed_en
//   feed_en     - advance one diagonal
//   pu_letters  - PU k slice at [k*NLC*LETTER_WIDTH +: NLC*LETTER_WIDTH]
//   pu_mask     - bit k set when PU k letters are valid
//   diag_idx    - diagonal number of the current output
//   feed_valid  - pu_letters/pu_mask/diag_idx refreshed this cycle
//   done        - one-cycle pulse after the last diagonal
module seq_feed_buffer #(
  parameter int SEQ_LENGTH   = 32,
  parameter int LETTER_WIDTH = 2,
  parameter int INPUT_WIDTH  = 8,
  parameter int NUM_PU       = 16,
  parameter int NLC          = 2,
  parameter int REVERSE      = 0,
  localparam int LPW         = INPUT_WIDTH / LETTER_WIDTH,
  localparam int G           = SEQ_LENGTH / NLC,
  localparam int NUM_WORDS   = SEQ_LENGTH / LPW,
  localparam int NUM_DIAG    = NUM_PU + G - 1,
  localparam int IW          = (NUM_DIAG > 1) ? $clog2(NUM_DIAG) : 1,
  localparam int SW          = NUM_PU * NLC * LETTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [INPUT_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   load_done,
  input  logic                   feed_en,
  output logic [SW-1:0]          pu_letters,
  output logic [NUM_PU-1:0]      pu_mask,
  output logic [IW-1:0]          diag_idx,
  output logic                   feed_valid,
  output logic                   done
);

  localparam int WW = $clog2(NUM_WORDS + 1);
  localparam int DW = $clog2(NUM_DIAG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_FEED,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           w_q;
  logic [DW-1:0]           d_q;
  logic [LETTER_WIDTH-1:0] seq_q [SEQ_LENGTH];
  logic [SW-1:0]           letters_q, letters_d;
  logic [NUM_PU-1:0]       mask_q, mask_d;
  logic [IW-1:0]           diag_q;
  logic                    feed_valid_q;

  logic clr;
  logic load_wr;
  logic accept;

  // Input-letter position that lands in storage slot s.
  function automatic int src_idx(input int s);
    return (REVERSE != 0) ? (SEQ_LENGTH - 1 - s) : s;
  endfunction

  // Next state and strobes. start wins over everything else in its cycle.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    load_wr = 1'b0;
    accept  = 1'b0;
    if (start) begin
      state_d = S_LOAD;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            load_wr = 1'b1;
            if (w_q == WW'(NUM_WORDS - 1)) state_d = S_READY;
          end
        end
        S_READY: begin
          // The feed_en that leaves READY already produces diagonal 0.
          if (feed_en) begin
            accept  = 1'b1;
            state_d = S_FEED;
          end
        end
        S_FEED: begin
          // d_q == NUM_DIAG means the last diagonal is on the outputs now.
          if (d_q == DW'(NUM_DIAG)) state_d = S_FINISH;
          else if (feed_en)         accept  = 1'b1;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Diagonal select: PU k takes group g where k + g == d.
  always_comb begin
    letters_d = '0;
    mask_d    = '0;
    for (int k = 0; k < NUM_PU; k++) begin
      for (int g = 0; g < G; g++) begin
        if (int'(d_q) == k + g) begin
          mask_d[k] = 1'b1;
          for (int n = 0; n < NLC; n++) begin
            letters_d[(k*NLC+n)*LETTER_WIDTH +: LETTER_WIDTH] = seq_q[g*NLC+n];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q          <= '0;
      d_q          <= '0;
      letters_q    <= '0;
      mask_q       <= '0;
      diag_q       <= '0;
      feed_valid_q <= 1'b0;
      for (int s = 0; s < SEQ_LENGTH; s++) seq_q[s] <= '0;
    end else begin
      feed_valid_q <= accept;
      if (clr) begin
        w_q <= '0;
        d_q <= '0;
        for (int s = 0; s < SEQ_LENGTH; s++) seq_q[s] <= '0;
      end
      if (load_wr) begin
        w_q <= w_q + WW'(1);
        for (int s = 0; s < SEQ_LENGTH; s++) begin
          if (w_q == WW'(src_idx(s) / LPW)) begin
            seq_q[s] <= in_data[(src_idx(s) % LPW)*LETTER_WIDTH +: LETTER_WIDTH];
          end
        end
      end
      // Feed outputs only change on an accepted diagonal; stalls hold them.
      if (accept) begin
        letters_q <= letters_d;
        mask_q    <= mask_d;
        diag_q    <= IW'(d_q);
        d_q       <= d_q + DW'(1);
      end
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign load_done  = (state_q == S_READY);
  assign done       = (state_q == S_FINISH);
  assign pu_letters = letters_q;
  assign pu_mask    = mask_q;
  assign diag_idx   = diag_q;
  assign feed_valid = feed_valid_q;

endmodule

// File: tb/tb_seq_feed_buffer.sv
// tb/tb_seq_feed_buffer.sv - self-checking bench for seq_feed_buffer
module tb_seq_feed_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, feed_en;
  logic [7:0]  in_data;
  logic        in_ready, load_done, feed_valid, done;
  logic [63:0] pu_letters;
  logic [15:0] pu_mask;
  logic [4:0]  diag_idx;

  logic        r_in_ready, r_load_done, r_feed_valid, r_done;
  logic [63:0] r_pu_letters;
  logic [15:0] r_pu_mask;
  logic [4:0]  r_diag_idx;

  logic        b_start, b_in_valid, b_feed_en;
  logic [15:0] b_in_data;
  logic        b_in_ready, b_load_done, b_feed_valid, b_done;
  logic [63:0] b_pu_letters;
  logic [7:0]  b_pu_mask;
  logic [4:0]  b_diag_idx;

  seq_feed_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_done(load_done), .feed_en(feed_en),
    .pu_letters(pu_letters), .pu_mask(pu_mask), .diag_idx(diag_idx),
    .feed_valid(feed_valid), .done(done));

  seq_feed_buffer #(.REVERSE(1)) u_rev (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r_in_ready), .load_done(r_load_done), .feed_en(feed_en),
    .pu_letters(r_pu_letters), .pu_mask(r_pu_mask), .diag_idx(r_diag_idx),
    .feed_valid(r_feed_valid), .done(r_done));

  seq_feed_buffer #(.SEQ_LENGTH(64), .NUM_PU(8), .NLC(4), .INPUT_WIDTH(16)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .load_done(b_load_done), .feed_en(b_feed_en),
    .pu_letters(b_pu_letters), .pu_mask(b_pu_mask), .diag_idx(b_diag_idx),
    .feed_valid(b_feed_valid), .done(b_done));

  int n_assert = 0;
  int n_fail   = 0;
  int ref_let [64];   // input letters in arrival order

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stored(input int s, input int slen, input bit rev);
    return rev ? ref_let[slen-1-s] : ref_let[s];
  endfunction

  function automatic logic [63:0] exp_let(input int d, input int npu, input int nlc,
                                          input int slen, input bit rev);
    logic [63:0] v;
    int g;
    v = '0;
    for (int k = 0; k < npu; k++) begin
      g = d - k;
      if (g >= 0 && g < slen / nlc)
        for (int n = 0; n < nlc; n++)
          v = v | (64'(stored(g*nlc+n, slen, rev)) << ((k*nlc+n)*2));
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_mask(input int d, input int npu, input int nlc,
                                           input int slen);
    logic [63:0] v;
    int g;
    v = '0;
    for (int k = 0; k < npu; k++) begin
      g = d - k;
      if (g >= 0 && g < slen / nlc) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic load_small(input bit use_start, input bit fixed, input bit toggle);
    int hs;
    int cyc;
    hs  = 0;
    cyc = 0;
    if (use_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("load_in_ready", in_ready, 1);
    chk("load_rev_in_ready", r_in_ready, 1);
    while (hs < 8 && cyc < 200) begin
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = fixed ? 8'hE4 : 8'($urandom);
      if (in_valid && in_ready) begin
        for (int j = 0; j < 4; j++) ref_let[hs*4+j] = int'((in_data >> (2*j)) & 8'h3);
        hs++;
      end
      step();
      cyc++;
      if (hs < 8) chk("load_done_early", load_done, 0);
    end
    in_valid = 1'b0;
    chk("load_handshakes", hs, 8);
    chk("load_done_rise", load_done, 1);
    chk("ready_in_ready", in_ready, 0);
    chk("rev_load_done", r_load_done, 1);
  endtask

  task automatic feed_small(input int stall_d, input int abort_d);
    int dones;
    dones = 0;
    for (int d = 0; d < 31; d++) begin
      feed_en = 1'b1;
      step();
      if (done) dones++;
      chk("feed_valid", feed_valid, 1);
      chk("diag_idx", diag_idx, d);
      chk("pu_mask", pu_mask, exp_mask(d, 16, 2, 32));
      chk("pu_letters", pu_letters, exp_let(d, 16, 2, 32, 1'b0));
      chk("rev_feed_valid", r_feed_valid, 1);
      chk("rev_diag_idx", r_diag_idx, d);
      chk("rev_pu_letters", r_pu_letters, exp_let(d, 16, 2, 32, 1'b1));
      chk("rev_pu_mask", r_pu_mask, exp_mask(d, 16, 2, 32));
      if (d == 0)  chk("mask_d0", pu_mask, 16'h0001);
      if (d == 15) chk("mask_d15", pu_mask, 16'hFFFF);
      if (d == 30) chk("mask_d30", pu_mask, 16'h8000);
      if (d == stall_d) begin
        feed_en = 1'b0;
        repeat (5) begin
          step();
          chk("stall_feed_valid", feed_valid, 0);
          chk("stall_diag_idx", diag_idx, d);
          chk("stall_pu_mask", pu_mask, exp_mask(d, 16, 2, 32));
          chk("stall_pu_letters", pu_letters, exp_let(d, 16, 2, 32, 1'b0));
        end
      end
      if (d == abort_d) begin
        start   = 1'b1;
        feed_en = 1'b1;
        step();
        start   = 1'b0;
        feed_en = 1'b0;
        chk("abort_feed_valid", feed_valid, 0);
        chk("abort_load_done", load_done, 0);
        chk("abort_in_ready", in_ready, 1);
        return;
      end
    end
    feed_en = 1'b0;
    step();
    chk("done_pulse", done, 1);
    chk("rev_done_pulse", r_done, 1);
    if (done) dones++;
    step();
    chk("done_clear", done, 0);
    chk("done_count", dones, 1);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_load_done", load_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int cyc;
    int dones;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; feed_en = 1'b0; in_data = '0;
    b_start = 1'b0; b_in_valid = 1'b0; b_feed_en = 1'b0; b_in_data = '0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_feed_valid", feed_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_pu_letters", pu_letters, 0);
    chk("rst_pu_mask", pu_mask, 0);
    chk("rst_diag_idx", diag_idx, 0);
    chk("rst_big_mask", b_pu_mask, 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_ready", in_ready, 0);

    // Fixed pattern, toggled valid, extra word after load, stall at d=7.
    load_small(1'b1, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h1B;
    step();
    step();
    in_valid = 1'b0;
    chk("extra_word_in_ready", in_ready, 0);
    chk("extra_word_load_done", load_done, 1);
    feed_en = 1'b1;
    step();
    chk("fixed_pu0_letters", pu_letters[3:0], 4'h4);
    chk("rev_pu0_letters", r_pu_letters[3:0], 4'hB);
    feed_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    load_small(1'b0, 1'b1, 1'b1);
    feed_small(7, -1);

    // Random load, restart mid-feed, new random load, full feed.
    load_small(1'b1, 1'b0, 1'b0);
    feed_small(-1, 10);
    load_small(1'b0, 1'b0, 1'b1);
    feed_small(-1, -1);

    // Reset in the middle of a load.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_feed_valid", feed_valid, 0);
    chk("arst_pu_mask", pu_mask, 0);
    chk("arst_pu_letters", pu_letters, 0);
    chk("arst_diag_idx", diag_idx, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_load_done", load_done, 0);

    // Wide configuration.
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    hs  = 0;
    cyc = 0;
    while (hs < 8 && cyc < 200) begin
      b_in_valid = 1'($urandom_range(0, 1));
      b_in_data  = 16'($urandom);
      if (b_in_valid && b_in_ready) begin
        for (int j = 0; j < 8; j++) ref_let[hs*8+j] = int'((b_in_data >> (2*j)) & 16'h3);
        hs++;
      end
      step();
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("big_handshakes", hs, 8);
    chk("big_load_done", b_load_done, 1);
    dones = 0;
    for (int d = 0; d < 23; d++) begin
      b_feed_en = 1'b1;
      step();
      if (b_done) dones++;
      chk("big_feed_valid", b_feed_valid, 1);
      chk("big_diag_idx", b_diag_idx, d);
      chk("big_pu_mask", b_pu_mask, exp_mask(d, 8, 4, 64));
      chk("big_pu_letters", b_pu_letters, exp_let(d, 8, 4, 64, 1'b0));
    end
    b_feed_en = 1'b0;
    step();
    chk("big_done", b_done, 1);
    if (b_done) dones++;
    step();
    chk("big_done_count", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
